ramp_adc_ctrl: RTL
==================

// Module: ramp_adc_ctrl
// PURPOSE
//  Sequencer that turns the LVDS-input comparator plus external RC ramp into a single-slope ADC.
//  Discharges the ramp, enables the ramp clock, and counts until the synchronized comparator trips.
//  Presents the count as a sample on a valid/ready interface.
//  Sits between the SB_IO comparator/ref-clock pins and audio/consumer logic, clocked from hf_osc (6 MHz).
// PARAMETERS
//  CNT_W        12  conversion counter / sample width; full scale = 2**CNT_W-1
//  DISCH_CYC    64  cycles ramp_dischg held high before each conversion (>=1)
//  SYNC_STAGES  2   comparator synchronizer depth (>=2); subtracted from captured count
// PORTS
//  clk          in   1      system clock (hf_osc domain)
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request one conversion; level-sensitive, sampled only in IDLE
//  cont         in   1      1 = auto-restart after each accepted sample
//  cmp_in       in   1      raw comparator output (D_IN from LVDS SB_IO), asynchronous
//  ramp_dischg  out  1      1 = external ramp held discharged
//  ramp_run     out  1      1 = gate ramp reference clock to EU_REF_CLK SB_IO
//  sample       out  CNT_W  conversion result, stable while sample_valid=1
//  sample_valid out  1      result available
//  sample_ready in   1      consumer accepts when valid&ready at posedge clk
//  overflow     out  1      sample reached full scale without a comparator trip
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, ramp_dischg=1, ramp_run=0, sample=0, sample_valid=0,
//   overflow=0, counters=0, sync chain=0. Reset mid-conversion aborts; no sample is produced.
//  FSM states: IDLE -> DISCH -> RAMP -> DONE -> (IDLE | DISCH)
//  IDLE:  ramp_dischg=1, ramp_run=0. Leave when start|cont -> DISCH with dcnt=0.
//  DISCH: ramp_dischg=1; dcnt++; on dcnt==DISCH_CYC-1 -> RAMP, cnt=0.
//  RAMP:  ramp_dischg=0, ramp_run=1; cnt++ each cycle.
//    - Trip = rising edge of synchronized cmp (cmp_s & ~cmp_s_d). The edge detector is primed on RAMP
//      entry: if cmp_s is already 1 on the first RAMP cycle, this counts as an immediate trip.
//    - On trip: sample = (cnt>=SYNC_STAGES) ? cnt-SYNC_STAGES : 0; overflow=0; -> DONE.
//    - If cnt == 2**CNT_W-1 with no trip: sample = all-ones; overflow=1; -> DONE.
//      Trip and overflow in the same cycle: trip wins.
//  DONE:  ramp_dischg=1, ramp_run=0, sample_valid=1. sample and overflow frozen until the handshake.
//    - On valid&ready: sample_valid=0 next cycle; -> DISCH if cont=1, else IDLE.
//    - No new conversion starts until the sample is accepted (no overrun, no drop).
//  Latency: DISCH_CYC + (trip cnt) + SYNC_STAGES + 1 cycles from leaving IDLE to sample_valid.
//  start/cont changes outside IDLE/DONE are ignored; start held high = back-to-back conversions.
//  Counter width: cnt is CNT_W bits and never wraps (saturation is handled by the overflow path).
//  All outputs registered; no combinational path from cmp_in or sample_ready to any output.
// STRUCTURE
//  ramp_adc_defs.vh: FSM state localparams (IDLE/DISCH/RAMP/DONE, 2-bit), default CNT_W/DISCH_CYC.
//  Sub-module cmp_sync: SYNC_STAGES-deep FF chain + registered rising-edge detect; reset clears chain.
//  Top holds FSM, discharge counter ($clog2(DISCH_CYC) bits), conversion counter, output registers.
// TESTING (CNT_W=8, DISCH_CYC=4, SYNC_STAGES=2)
//  1. Reset, pulse start, model cmp rising 50 cycles into RAMP -> sample=48, overflow=0,
//     valid 4+50+3 cycles after start.
//  2. cmp never rises -> sample=255, overflow=1; ramp_run drops the cycle DONE is entered.
//  3. cmp held high before RAMP -> sample=0, overflow=0.
//  4. cont=1, ready low 20 cycles -> sample/valid held stable, ramp_dischg=1 throughout;
//     after ready, DISCH restarts next cycle.
//  5. Assert rst mid-RAMP -> next cycle IDLE, ramp_dischg=1, ramp_run=0, valid=0; no sample emitted.
//  6. start pulsed during RAMP and DONE -> ignored; exactly one sample produced.

Source files
------------

// File: rtl/ramp_adc_ctrl_pkg.sv
// Shared types and defaults for the single-slope ramp ADC sequencer.
package ramp_adc_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDisch = 2'd1,
        StRamp  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DefaultCntW       = 12;
    localparam int unsigned DefaultDischCyc   = 64;
    localparam int unsigned DefaultSyncStages = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ramp_adc_ctrl_cmp_sync.sv
// Comparator synchronizer with a primable rising-edge detector.
module ramp_adc_ctrl_cmp_sync
    import ramp_adc_ctrl_pkg::*;
#(
    parameter int unsigned SyncStages = DefaultSyncStages
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cmp_i,
    input  logic prime_i,
    output logic rise_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;
    logic                  cmp_s;

    assign cmp_s = sync_q[SyncStages-1];

    // While primed the previous value reads as 0, so a comparator already high
    // at the start of a ramp registers as a rising edge on the first cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], cmp_i};
            prev_q <= prime_i ? 1'b0 : cmp_s;
        end
    end

    assign rise_o = cmp_s & ~prev_q;

endmodule

// File: rtl/ramp_adc_ctrl.sv
// Single-slope ADC sequencer: discharge, ramp and count until the comparator trips.
module ramp_adc_ctrl
    import ramp_adc_ctrl_pkg::*;
#(
    parameter int unsigned CntW       = DefaultCntW,
    parameter int unsigned DischCyc   = DefaultDischCyc,
    parameter int unsigned SyncStages = DefaultSyncStages
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            cont_i,
    input  logic            cmp_i,
    output logic            ramp_dischg_o,
    output logic            ramp_run_o,
    output logic [CntW-1:0] sample_o,
    output logic            sample_valid_o,
    input  logic            sample_ready_i,
    output logic            overflow_o,
    output logic            busy_o
);

    localparam int unsigned     DcntW    = cnt_width(DischCyc);
    localparam logic [DcntW-1:0] DcntLast = DcntW'(DischCyc - 1);
    localparam logic [CntW-1:0]  CntMax   = '1;
    localparam logic [CntW-1:0]  SyncSub  = CntW'(SyncStages);

    state_e            state_q, state_d;
    logic [DcntW-1:0]  dcnt_q, dcnt_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   sample_q, sample_d;
    logic              overflow_q, overflow_d;
    logic              dischg_q, run_q, valid_q, busy_q;
    logic              trip;

    ramp_adc_ctrl_cmp_sync #(
        .SyncStages(SyncStages)
    ) u_cmp_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cmp_i  (cmp_i),
        .prime_i(state_q != StRamp),
        .rise_o (trip)
    );

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (start_i || cont_i) begin
                    state_d = StDisch;
                    dcnt_d  = '0;
                end
            end
            StDisch: begin
                if (dcnt_q == DcntLast) begin
                    state_d = StRamp;
                    cnt_d   = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            StRamp: begin
                // Trip takes priority over full scale; the synchronizer delay is removed.
                if (trip) begin
                    sample_d   = (cnt_q >= SyncSub) ? cnt_q - SyncSub : '0;
                    overflow_d = 1'b0;
                    state_d    = StDone;
                end else if (cnt_q == CntMax) begin
                    sample_d   = '1;
                    overflow_d = 1'b1;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (sample_ready_i) begin
                    state_d = cont_i ? StDisch : StIdle;
                    dcnt_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            dcnt_q     <= '0;
            cnt_q      <= '0;
            sample_q   <= '0;
            overflow_q <= 1'b0;
            dischg_q   <= 1'b1;
            run_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            overflow_q <= overflow_d;
            dischg_q   <= (state_d != StRamp);
            run_q      <= (state_d == StRamp);
            valid_q    <= (state_d == StDone);
            busy_q     <= (state_d != StIdle);
        end
    end

    assign ramp_dischg_o  = dischg_q;
    assign ramp_run_o     = run_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign overflow_o     = overflow_q;
    assign busy_o         = busy_q;

endmodule
